// File: rtl/id_decode_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode_pipe_pkg
//  Description : Shared MIPS decode definitions. It holds the opcode and funct
//                codes, the class-flag bit indices, the fixed-width decoded
//                field bundle, and the supported-set helpers that the
//                reserved-instruction check uses (DECODE_RI_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
package id_decode_pipe_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_COP0     = 6'h10;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;   // first of the contiguous ALU block
    localparam logic [5:0] FN_NOR   = 6'h27;   // last of the contiguous ALU block
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Class-flag bit positions inside id_fields_t.flags
    localparam int FLG_RTYPE  = 0;
    localparam int FLG_BRANCH = 1;
    localparam int FLG_JUMP   = 2;
    localparam int FLG_LOAD   = 3;
    localparam int FLG_STORE  = 4;
    localparam int NUM_FLAGS  = 5;

    // Fixed-width part of a decoded instruction. The PC- and EXT-width values
    // are carried beside it because their widths depend on parameters.
    typedef struct packed {
        logic [5:0]           opcode;
        logic [4:0]           rs;
        logic [4:0]           rt;
        logic [4:0]           rd;
        logic [4:0]           shamt;
        logic [5:0]           funct;
        logic [NUM_FLAGS-1:0] flags;
        logic                 ri;
    } id_fields_t;

    function automatic logic op_supported(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                          OP_BLEZ, OP_BGTZ, OP_ADDI, OP_ADDIU, OP_SLTI,
                          OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
                          OP_COP0, OP_SPECIAL2, OP_LB, OP_LH, OP_LW, OP_LBU,
                          OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic fn_supported(input logic [5:0] fn);
        return fn inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                          FN_JR, FN_JALR, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                          [FN_ADD:FN_NOR], FN_SLT, FN_SLTU};
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_decode_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode_pipe_if
//  Description : Handshake and decoded-output bundle of the decode stage.
//                The "master" modport is the environment side (IF stage and
//                register-read consumer). The "slave" modport is the stage.
//  Ports       : in_valid/in_ready/in_instr/in_pc    upstream handshake
//                out_valid/out_ready                  downstream handshake
//                opcode..funct, imm_ext, targets, class flags, ri
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_decode_pipe_if #(
    parameter int PC_W  = 32,
    parameter int EXT_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [EXT_W-1:0]  imm_ext;
    logic [PC_W-1:0]   br_target;
    logic [PC_W-1:0]   j_target;
    logic [PC_W-1:0]   pc_plus4;
    logic              is_rtype;
    logic              is_branch;
    logic              is_jump;
    logic              is_load;
    logic              is_store;
    logic              ri;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct, imm_ext,
               br_target, j_target, pc_plus4, is_rtype, is_branch, is_jump,
               is_load, is_store, ri
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct, imm_ext,
               br_target, j_target, pc_plus4, is_rtype, is_branch, is_jump,
               is_load, is_store, ri
    );
endinterface
`default_nettype wire

// File: rtl/id_field_ext.sv
`default_nettype none
// ============================================================================
//  Module      : id_field_ext
//  Description : Combinational field splitter. It takes instr+pc and returns
//                the fields, the extended immediate, pc+4, the branch and
//                jump targets, the class flags and the reserved-instruction
//                flag. The reserved check exists only with DECODE_RI_EN.
//  Ports       : i_instr, i_pc -> o_fields, o_imm_ext, o_pc_plus4,
//                o_br_target, o_j_target
//  Revision    : 1.0 - initial release
// ============================================================================
module id_field_ext
    import id_decode_pipe_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int EXT_W = 32
) (
    input  wire logic [31:0]      i_instr,
    input  wire logic [PC_W-1:0]  i_pc,
    output id_fields_t            o_fields,
    output logic [EXT_W-1:0]      o_imm_ext,
    output logic [PC_W-1:0]       o_pc_plus4,
    output logic [PC_W-1:0]       o_br_target,
    output logic [PC_W-1:0]       o_j_target
);
    logic [5:0]           w_op;
    logic [5:0]           w_fn;
    logic [15:0]          w_imm16;
    logic                 w_ri;
    logic [NUM_FLAGS-1:0] w_flags;
    logic [EXT_W-1:0]     w_lui;

    assign w_op    = i_instr[31:26];
    assign w_fn    = i_instr[5:0];
    assign w_imm16 = i_instr[15:0];

`ifdef DECODE_RI_EN
    assign w_ri = !op_supported(w_op) || ((w_op == OP_RTYPE) && !fn_supported(w_fn));
`else
    assign w_ri = 1'b0;
`endif

    always_comb begin
        w_flags            = '0;
        w_flags[FLG_RTYPE] = (w_op == OP_RTYPE);
        case (w_op)
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: w_flags[FLG_BRANCH] = 1'b1;
            OP_J, OP_JAL:                               w_flags[FLG_JUMP]   = 1'b1;
            OP_RTYPE:         w_flags[FLG_JUMP] = (w_fn == FN_JR) || (w_fn == FN_JALR);
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:        w_flags[FLG_LOAD]   = 1'b1;
            OP_SB, OP_SH, OP_SW:                        w_flags[FLG_STORE]  = 1'b1;
            default: ;
        endcase
        // A reserved instruction still flows but must not steer any later unit.
        if (w_ri) begin
            w_flags = '0;
        end
    end

    // lui places imm16 in bits [31:16]. For a narrow EXT_W the top is cut off.
    if (EXT_W > 32) begin : g_lui_wide
        assign w_lui = {{(EXT_W-32){1'b0}}, w_imm16, 16'h0000};
    end else if (EXT_W == 32) begin : g_lui_exact
        assign w_lui = {w_imm16, 16'h0000};
    end else begin : g_lui_narrow
        assign w_lui = {w_imm16[EXT_W-17:0], 16'h0000};
    end

    always_comb begin
        case (w_op)
            OP_ANDI, OP_ORI, OP_XORI: o_imm_ext = {{(EXT_W-16){1'b0}}, w_imm16};
            OP_LUI:                   o_imm_ext = w_lui;
            default:                  o_imm_ext = {{(EXT_W-16){w_imm16[15]}}, w_imm16};
        endcase
    end

    assign o_pc_plus4  = i_pc + PC_W'(4);
    assign o_br_target = o_pc_plus4 + {{(PC_W-18){w_imm16[15]}}, w_imm16, 2'b00};

    if (PC_W > 28) begin : g_jt_upper
        assign o_j_target = {o_pc_plus4[PC_W-1:28], i_instr[25:0], 2'b00};
    end else begin : g_jt_exact
        assign o_j_target = {i_instr[25:0], 2'b00};
    end

    assign o_fields = '{opcode: w_op,
                        rs:     i_instr[25:21],
                        rt:     i_instr[20:16],
                        rd:     i_instr[15:11],
                        shamt:  i_instr[10:6],
                        funct:  w_fn,
                        flags:  w_flags,
                        ri:     w_ri};
endmodule
`default_nettype wire

// File: rtl/id_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode_pipe
//  Description : Registered MIPS instruction-decode stage. Decode happens
//                combinationally in front of a 2-entry skid buffer: a main
//                register that drives the outputs plus one skid register.
//                in_ready = !skid_valid, so it comes straight from a flop.
//                DECODE_RI_EN enables the reserved-instruction flag.
//  Ports       : clk, reset (sync, active-high), flush
//                bus : id_decode_pipe_if.slave (handshakes + decoded outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module id_decode_pipe
    import id_decode_pipe_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int EXT_W = 32
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        flush,
    id_decode_pipe_if.slave  bus
);
    localparam int c_bundle_w = $bits(id_fields_t) + EXT_W + 3*PC_W;

    id_fields_t               w_fields;
    logic [EXT_W-1:0]         w_imm_ext;
    logic [PC_W-1:0]          w_pc_plus4;
    logic [PC_W-1:0]          w_br_target;
    logic [PC_W-1:0]          w_j_target;
    logic [c_bundle_w-1:0]    w_bundle;
    logic                     w_accept;
    logic                     w_drain;

    logic [c_bundle_w-1:0]    r_main;
    logic [c_bundle_w-1:0]    r_skid;
    logic                     r_main_vld;
    logic                     r_skid_vld;

    id_fields_t               w_out_fields;
    logic [EXT_W-1:0]         w_out_imm;
    logic [PC_W-1:0]          w_out_pc4;
    logic [PC_W-1:0]          w_out_br;
    logic [PC_W-1:0]          w_out_jt;

    id_field_ext #(
        .PC_W  (PC_W),
        .EXT_W (EXT_W)
    ) u_field_ext (
        .i_instr     (bus.in_instr),
        .i_pc        (bus.in_pc),
        .o_fields    (w_fields),
        .o_imm_ext   (w_imm_ext),
        .o_pc_plus4  (w_pc_plus4),
        .o_br_target (w_br_target),
        .o_j_target  (w_j_target)
    );

    assign w_bundle = {w_fields, w_imm_ext, w_pc_plus4, w_br_target, w_j_target};
    assign w_accept = bus.in_valid && !r_skid_vld;
    assign w_drain  = r_main_vld && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            // Both clear everything, so the fields also read 0 afterwards.
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            // in_ready is low here, so the only possible event is a drain.
            if (w_drain) begin
                r_main     <= r_skid;
                r_skid_vld <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_vld || bus.out_ready) begin
                r_main     <= w_bundle;
                r_main_vld <= 1'b1;
            end else begin
                r_skid     <= w_bundle;
                r_skid_vld <= 1'b1;
            end
        end else if (w_drain) begin
            // Fields keep the drained values, only the valid bit drops.
            r_main_vld <= 1'b0;
        end
    end

    assign {w_out_fields, w_out_imm, w_out_pc4, w_out_br, w_out_jt} = r_main;

    assign bus.in_ready  = !r_skid_vld;
    assign bus.out_valid = r_main_vld;
    assign bus.opcode    = w_out_fields.opcode;
    assign bus.rs        = w_out_fields.rs;
    assign bus.rt        = w_out_fields.rt;
    assign bus.rd        = w_out_fields.rd;
    assign bus.shamt     = w_out_fields.shamt;
    assign bus.funct     = w_out_fields.funct;
    assign bus.imm_ext   = w_out_imm;
    assign bus.pc_plus4  = w_out_pc4;
    assign bus.br_target = w_out_br;
    assign bus.j_target  = w_out_jt;
    assign bus.is_rtype  = w_out_fields.flags[FLG_RTYPE];
    assign bus.is_branch = w_out_fields.flags[FLG_BRANCH];
    assign bus.is_jump   = w_out_fields.flags[FLG_JUMP];
    assign bus.is_load   = w_out_fields.flags[FLG_LOAD];
    assign bus.is_store  = w_out_fields.flags[FLG_STORE];
    assign bus.ri        = w_out_fields.ri;
endmodule
`default_nettype wire

// File: tb/tb_id_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_decode_pipe
//  Description : Self-checking bench for id_decode_pipe. A queue-based
//                reference model predicts the outputs on every cycle, and
//                directed steps pin concrete decode values. Honours
//                DECODE_RI_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_decode_pipe;
    localparam int PC_W  = 32;
    localparam int EXT_W = 32;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [31:0] br;
        logic [31:0] jt;
        logic        rtype;
        logic        branch;
        logic        jump;
        logic        load;
        logic        store;
        logic        ri;
    } dec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    id_decode_pipe_if #(.PC_W(PC_W), .EXT_W(EXT_W)) bus ();

    id_decode_pipe #(.PC_W(PC_W), .EXT_W(EXT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // ---------------- reference decode, straight from the instruction rules
    function automatic dec_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        dec_t        d;
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [15:0] im = ins[15:0];
        logic [31:0] sx = {{16{im[15]}}, im};
        logic        r  = 1'b0;
        d.op = op; d.rs = ins[25:21]; d.rt = ins[20:16];
        d.rd = ins[15:11]; d.sh = ins[10:6]; d.fn = fn;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) d.imm = {16'h0000, im};
        else if (op == 6'h0F)                           d.imm = {im, 16'h0000};
        else                                            d.imm = sx;
        d.pc4 = pc + 32'd4;
        d.br  = d.pc4 + (sx << 2);
        d.jt  = {d.pc4[31:28], ins[25:0], 2'b00};
`ifdef DECODE_RI_EN
        r = !(op inside {6'h00,6'h01,6'h02,6'h03,6'h04,6'h05,6'h06,6'h07,6'h08,
                         6'h09,6'h0A,6'h0B,6'h0C,6'h0D,6'h0E,6'h0F,6'h1C,6'h20,
                         6'h21,6'h23,6'h24,6'h25,6'h28,6'h29,6'h2B,6'h10})
            || (op == 6'h00 && !(fn inside {6'h00,6'h02,6'h03,6'h04,6'h06,6'h07,
                         6'h08,6'h09,6'h10,6'h11,6'h12,6'h13,6'h18,6'h19,6'h1A,
                         6'h1B,[6'h20:6'h27],6'h2A,6'h2B}));
`endif
        d.ri     = r;
        d.rtype  = !r && (op == 6'h00);
        d.branch = !r && (op inside {6'h01,6'h04,6'h05,6'h06,6'h07});
        d.jump   = !r && ((op inside {6'h02,6'h03}) || (op == 6'h00 && (fn inside {6'h08,6'h09})));
        d.load   = !r && (op inside {6'h20,6'h21,6'h23,6'h24,6'h25});
        d.store  = !r && (op inside {6'h28,6'h29,6'h2B});
        return d;
    endfunction

    function automatic dec_t dut_word();
        dec_t d;
        d.op = bus.opcode; d.rs = bus.rs; d.rt = bus.rt; d.rd = bus.rd;
        d.sh = bus.shamt; d.fn = bus.funct; d.imm = bus.imm_ext;
        d.pc4 = bus.pc_plus4; d.br = bus.br_target; d.jt = bus.j_target;
        d.rtype = bus.is_rtype; d.branch = bus.is_branch; d.jump = bus.is_jump;
        d.load = bus.is_load; d.store = bus.is_store; d.ri = bus.ri;
        return d;
    endfunction

    function automatic logic [31:0] dut_instr();
        return {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- per-cycle compare against the FIFO model
    dec_t q[$];
    dec_t shown    = '0;
    bit   model_ok = 1'b0;

    always @(negedge clk) begin
        dec_t exp;
        bit   acc;
        bit   drn;
        if (model_ok) begin
            exp = (q.size() > 0) ? q[0] : shown;
            check("sb_valid_ready", {bus.out_valid, bus.in_ready},
                  {q.size() > 0, q.size() < 2});
            check("sb_bundle", dut_word(), exp);
        end
        // Inputs are stable until the coming rising edge; predict its effect.
        if (reset) begin
            q.delete();
            shown    = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (flush) begin
                q.delete();
                shown = '0;
            end else begin
                acc = bus.in_valid && (q.size() < 2);
                drn = (q.size() > 0) && bus.out_ready;
                if (drn) shown = q.pop_front();
                if (acc) q.push_back(model_decode(bus.in_instr, bus.in_pc));
            end
        end
    end

    // ---------------- stimulus
    task automatic send1(input logic [31:0] ins, input logic [31:0] pc);
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [0:15] = '{6'h00,6'h01,6'h02,6'h03,6'h04,6'h09,6'h0C,6'h0D,
                                    6'h0E,6'h0F,6'h23,6'h20,6'h2B,6'h28,6'h3F,6'h1C};
        logic [5:0]  fns [0:7]  = '{6'h08,6'h09,6'h20,6'h21,6'h2A,6'h01,6'h3E,6'h00};
        logic [31:0] w = $urandom();
        logic [5:0]  op;
        if ($urandom_range(0, 4) == 0) return w;
        op = ops[$urandom_range(0, 15)];
        w[31:26] = op;
        if (op == 6'h00) w[5:0] = fns[$urandom_range(0, 7)];
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        // Pin the model itself with hand-computed decode values.
        check("model_addiu_imm", model_decode(32'h2408FFFC, 32'h3000).imm, 32'hFFFFFFFC);
        check("model_lui_imm",   model_decode(32'h3C081234, 32'h0).imm,    32'h12340000);
        check("model_beq_br",    model_decode(32'h1109FFFF, 32'h3010).br,  32'h00003010);
        check("model_j_jt",      model_decode(32'h08000C00, 32'h3000).jt,  32'h00003000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_fields",    dut_word(),    '0);
        @(posedge clk); #1 reset = 1'b0;

        send1(32'h2408FFFC, 32'h00003000);
        check("addiu_valid", bus.out_valid, 1'b1);
        check("addiu_rt",    bus.rt,        5'd8);
        check("addiu_imm",   bus.imm_ext,   32'hFFFFFFFC);
        check("addiu_pc4",   bus.pc_plus4,  32'h00003004);
        send1(32'h3508FFFF, 32'h00003004);
        check("ori_imm",     bus.imm_ext,   32'h0000FFFF);
        send1(32'h3C081234, 32'h00003008);
        check("lui_imm",     bus.imm_ext,   32'h12340000);
        send1(32'h1109FFFF, 32'h00003010);
        check("beq_flag",    bus.is_branch, 1'b1);
        check("beq_target",  bus.br_target, 32'h00003010);
        send1(32'h08000C00, 32'h00003000);
        check("j_flag",      bus.is_jump,   1'b1);
        check("j_target",    bus.j_target,  32'h00003000);
        send1(32'h03E00008, 32'h00003020);
        check("jr_flags", {bus.is_rtype, bus.is_jump, bus.is_branch}, 3'b110);
        send1(32'hFC000000, 32'h00003024);
`ifdef DECODE_RI_EN
        check("ri_flag", bus.ri, 1'b1);
`else
        check("ri_flag", bus.ri, 1'b0);
`endif
        check("ri_class", {bus.is_rtype, bus.is_branch, bus.is_jump, bus.is_load, bus.is_store}, 5'b0);

        // Back-pressure: A to main, B to skid, C held until the skid empties.
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_instr = 32'h8C410004; bus.in_pc = 32'h00004000;
        @(negedge clk);
        @(posedge clk); #1 bus.in_instr = 32'hAC620008; bus.in_pc = 32'h00004004;
        @(negedge clk);
        check("bp_first", dut_instr(), 32'h8C410004);
        @(posedge clk); #1 bus.in_instr = 32'h00851020; bus.in_pc = 32'h00004008;
        @(negedge clk);
        check("bp_full_ready", bus.in_ready, 1'b0);
        check("bp_hold_a",     dut_instr(),  32'h8C410004);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_still_a",    dut_instr(),  32'h8C410004);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_b",          dut_instr(),  32'h AC620008);
        check("bp_ready_back", bus.in_ready, 1'b1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_c",          dut_instr(),  32'h00851020);
        check("bp_c_pc4",      bus.pc_plus4, 32'h0000400C);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_empty",      bus.out_valid, 1'b0);

        // Flush with main and skid full and a third word offered.
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_instr = 32'h8C0A0010; bus.in_pc = 32'h00005000;
        @(posedge clk); #1 bus.in_instr = 32'hAC0B0014; bus.in_pc = 32'h00005004;
        @(posedge clk); #1 bus.in_instr = 32'h014B6020; bus.in_pc = 32'h00005008; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        check("flush_valid", bus.out_valid, 1'b0);
        check("flush_ready", bus.in_ready,  1'b1);
        repeat (3) begin
            @(negedge clk);
            check("flush_no_leak", bus.out_valid, 1'b0);
        end

        // Randomized traffic, including pc wrap-around, flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset         = ($urandom_range(0, 199) == 0);
            flush         = ($urandom_range(0, 49) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.in_instr  = rand_instr();
            pc            = $urandom() & 32'hFFFFFFFC;
            if ($urandom_range(0, 7) == 0) pc = 32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4);
            bus.in_pc     = pc;
        end
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
